enemy_spawner: RTL and testbench
================================

# enemy_spawner

Upstream companion of the enemy y-coordinate counters. Owns the 10 enemy slots, spawns a new enemy into the lowest free slot on a fixed interval, and gives it a pseudo-random x coordinate. It frees a slot when that enemy is destroyed or reaches the bottom edge. It counts escaped enemies against a lives budget and asserts game-over. Its `c_en` output drives the per-slot enables of the y counters; their `touch_edge` outputs and the collision unit's `des` outputs feed back into it.

## Interface

Parameters:
- `SPAWN_PERIOD`, default 50000000: clock cycles between spawn attempts (1 s at 50 MHz).
- `X_MAX`, default 152: largest legal x coordinate (160-pixel screen, 8-pixel sprite); must be ≥ 127.
- `START_LIVES`, default 3: lives loaded at reset and on `start`; range 1..3.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a new game.
- `run`  in  1  spawn timer enable (pause when low).
- `touch_edge`  in  10  per-slot "enemy at bottom edge" level, from the y counters.
- `des`  in  10  per-slot destroyed strobe, from collision logic.
- `c_en`  out  10  per-slot active flag (enable to the y counters).
- `x_out`  out  80  packed x coordinates; slot i is `x_out[8i+7:8i]`.
- `spawn_pulse`  out  1  high for one cycle when a slot is filled.
- `lives`  out  2  remaining lives.
- `game_over`  out  1  high while lives are 0.

## Operation

- **Reset values:**
  - `c_en`=0, `x_out`=0, `spawn_pulse`=0, `lives`=START_LIVES, `game_over`=0.
  - Timer=0, LFSR=8'hA5, touch history=0.
- **LFSR:**
  - 8-bit Fibonacci, taps 8,6,5,4; shifts left, feedback into bit 0.
  - Advances every cycle regardless of `run` and `game_over`.
  - Never reaches 0.
- **x mapping:** `xr` = LFSR if LFSR ≤ X_MAX, else LFSR − (X_MAX+1). Result is 8 bits and always ≤ X_MAX.
- **Timer:**
  - Counts while `run` && !`game_over`; holds otherwise.
  - At SPAWN_PERIOD−1 it wraps to 0 and raises a spawn request for that cycle.
- **Spawn:**
  - On a spawn request, select the lowest i with `c_en[i]`=0, using the current registered value.
  - Set `c_en[i]`, latch `x_out[i]`=`xr`, and pulse `spawn_pulse`.
  - If all slots are active, the request is dropped: no pulse, timer still wraps.
- **Release:** `c_en[i]` clears if `c_en[i]` && (`des[i]` || `touch_rise[i]`).
  - `touch_rise[i]` = `touch_edge[i]` && !previous `touch_edge[i]`.
  - Only rising edges count. The y counter holds `touch_edge` high while parked at the edge, and a held level must not release a slot twice.
  - `x_out[i]` keeps its value after release.
- **Same-cycle spawn and release:** the spawn choice uses pre-update `c_en`. A slot being released in a cycle is therefore not free in that cycle, and no conflict can occur.
- **Lives:**
  - `lives` decreases by the number of slots with `c_en[i]` && `touch_rise[i]` && !`des[i]` in that cycle, saturating at 0.
  - When `des` and `touch_rise` coincide on a slot, the enemy counts as destroyed.
- **Game over:**
  - `game_over` is set on the edge where `lives` becomes 0.
  - On that same edge `c_en` is forced to 0 and spawning stops.
- **start:**
  - Reloads START_LIVES, clears `game_over`, `c_en`, and the timer.
  - Overrides every other update in that cycle. It does not touch the LFSR or `x_out`.

## Timing

- Spawn: request cycle at timer=SPAWN_PERIOD−1. `c_en[i]`, `x_out[i]`, and `spawn_pulse` update on the following edge, a registered 1-cycle latency. `spawn_pulse` lasts exactly 1 cycle.
- First spawn after `start` (with `run`=1): SPAWN_PERIOD edges after `start` deasserts.
- Release: `des` or the rising `touch_edge` is sampled at edge N; `c_en` clears at edge N. `touch_rise` uses history registered at edge N−1, so there is no added latency beyond one register.
- `lives` and `game_over` update on the same edge as the release.
- Async `reset` mid-game: outputs go to reset values immediately, independent of `clk`. The first spawn needs `run` high again for SPAWN_PERIOD cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan

All scenarios use SPAWN_PERIOD=4.

- **First spawn:** reset, then `run`=1.
  - `spawn_pulse` at edge 4; `c_en`=10'h001.
  - `x_out[7:0]` equals the mapped LFSR value at the request cycle, which is ≤ 152.
- **Fill:** keep `run`=1 for 44 cycles.
  - `c_en` reaches 10'h3FF after the 10th spawn.
  - The 11th request gives no `spawn_pulse`, and `c_en` stays 10'h3FF.
- **Reuse:** with `c_en`=10'h3FF, pulse `des[3]`.
  - `c_en`=10'h3F7 next edge.
  - The next spawn sets bit 3 with a new `x_out[31:24]`.
- **Simultaneous escapes:** `touch_edge[0]` and `touch_edge[1]` rise together with lives=3.
  - `lives`=1 and `c_en[1:0]`=0 on that edge.
  - Holding `touch_edge` high changes nothing further.
  - A third rising edge gives `lives`=0, `game_over`=1, `c_en`=0, and no further spawns.
- **Coincident des + touch on one slot:** lives unchanged, slot cleared.
- **Restart and reset:** `start` during `game_over` gives lives=3, `game_over`=0, and a spawn 4 cycles later. Async `reset` asserted mid-cycle clears `c_en` before the next `clk` edge.

Source files
------------

// File: rtl/enemy_spawner_if.sv
// Bundle between the enemy spawner and its surroundings (game control, y counters,
// collision unit).
//   start        game control -> spawner   one-cycle new-game pulse
//   run          game control -> spawner   spawn timer enable
//   touch_edge   y counters   -> spawner   per-slot "at bottom edge" level
//   des          collision    -> spawner   per-slot destroyed strobe
//   c_en         spawner -> y counters     per-slot active flag
//   x_out        spawner -> renderer       packed x coordinates, slot i at [8i+7:8i]
//   spawn_pulse  spawner -> *              one-cycle pulse when a slot is filled
//   lives        spawner -> *              remaining lives
//   game_over    spawner -> *              high while lives are 0
interface enemy_spawner_if;
  logic        start;
  logic        run;
  logic [9:0]  touch_edge;
  logic [9:0]  des;
  logic [9:0]  c_en;
  logic [79:0] x_out;
  logic        spawn_pulse;
  logic [1:0]  lives;
  logic        game_over;

  modport master (
    output start, run, touch_edge, des,
    input  c_en, x_out, spawn_pulse, lives, game_over
  );

  modport slave (
    input  start, run, touch_edge, des,
    output c_en, x_out, spawn_pulse, lives, game_over
  );
endinterface

// File: rtl/enemy_spawner.sv
// Enemy slot manager. Spawns an enemy into the lowest free of 10 slots every
// SPAWN_PERIOD cycles of run time, gives it a pseudo-random x coordinate, frees a slot
// when its enemy is destroyed or first touches the bottom edge, and counts escapes
// against a lives budget.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    enemy_spawner_if.slave (start/run/touch_edge/des in; c_en/x_out/
//          spawn_pulse/lives/game_over out, all registered)
module enemy_spawner #(
  parameter int unsigned SPAWN_PERIOD = 50000000,
  parameter int unsigned X_MAX        = 152,
  parameter int unsigned START_LIVES  = 3
) (
  input logic             clk,
  input logic             reset,
  enemy_spawner_if.slave  bus
);

  localparam int unsigned TimerW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(SPAWN_PERIOD - 1);
  localparam logic [1:0] LivesInit = 2'(START_LIVES);
  localparam logic [7:0] XMax = 8'(X_MAX);
  localparam logic [7:0] XWrap = 8'(X_MAX + 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [9:0]        touch_q;
  logic [9:0]        c_en_q, c_en_d;
  logic [9:0][7:0]   x_q, x_d;
  logic              pulse_q, pulse_d;
  logic [1:0]        lives_q, lives_d;
  logic              game_over_q, game_over_d;

  logic [7:0] xr;
  logic       timer_en;
  logic       spawn_req;
  logic [9:0] touch_rise;
  logic [9:0] release_v;
  logic [9:0] escape;
  logic [3:0] esc_cnt;
  logic [1:0] lives_after;
  logic [9:0] spawn_oh;
  logic       end_game;

  always_comb begin
    // Taps 8,6,5,4 (bits 7,5,4,3); a nonzero seed never reaches the all-zero state.
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    xr     = (lfsr_q <= XMax) ? lfsr_q : lfsr_q - XWrap;

    timer_en  = bus.run && !game_over_q;
    spawn_req = timer_en && (timer_q == TimerLast);
    timer_d   = timer_q;
    if (timer_en) begin
      timer_d = spawn_req ? '0 : timer_q + 1'b1;
    end

    // Only the rising edge of touch_edge counts; the y counter parks at the edge.
    touch_rise = bus.touch_edge & ~touch_q;
    release_v  = c_en_q & (bus.des | touch_rise);
    escape     = c_en_q & touch_rise & ~bus.des;

    esc_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      esc_cnt = esc_cnt + 4'(escape[i]);
    end
    lives_after = ({2'b00, lives_q} <= esc_cnt) ? 2'b00 : lives_q - esc_cnt[1:0];
    end_game    = (lives_q != 2'b00) && (lives_after == 2'b00);

    // Lowest free slot of the pre-update c_en, so a slot being released is not reused
    // in the same cycle.
    spawn_oh = '0;
    for (int i = 9; i >= 0; i--) begin
      if (!c_en_q[i]) spawn_oh = 10'b1 << i;
    end
    if (!spawn_req) spawn_oh = '0;

    c_en_d      = (c_en_q & ~release_v) | spawn_oh;
    pulse_d     = |spawn_oh;
    lives_d     = lives_after;
    game_over_d = game_over_q;
    x_d         = x_q;
    for (int i = 0; i < 10; i++) begin
      if (spawn_oh[i]) x_d[i] = xr;
    end

    if (end_game) begin
      c_en_d      = '0;
      pulse_d     = 1'b0;
      game_over_d = 1'b1;
      x_d         = x_q;
    end

    if (bus.start) begin
      lives_d     = LivesInit;
      game_over_d = 1'b0;
      c_en_d      = '0;
      timer_d     = '0;
      pulse_d     = 1'b0;
      x_d         = x_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q     <= '0;
      lfsr_q      <= 8'hA5;
      touch_q     <= '0;
      c_en_q      <= '0;
      x_q         <= '0;
      pulse_q     <= 1'b0;
      lives_q     <= LivesInit;
      game_over_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      touch_q     <= bus.touch_edge;
      c_en_q      <= c_en_d;
      x_q         <= x_d;
      pulse_q     <= pulse_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.c_en        = c_en_q;
  assign bus.x_out       = x_q;
  assign bus.spawn_pulse = pulse_q;
  assign bus.lives       = lives_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_enemy_spawner.sv
module tb_enemy_spawner;
  localparam int P  = 4;
  localparam int XM = 152;
  localparam int SL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  enemy_spawner_if bus ();

  enemy_spawner #(
    .SPAWN_PERIOD(P),
    .X_MAX(XM),
    .START_LIVES(SL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_timer, m_lives, m_lfsr;
  bit         m_go, m_pulse;
  bit [9:0]   m_act, m_prev;
  logic [7:0] m_x [10];

  typedef struct {
    bit       start;
    bit       run;
    bit [9:0] touch;
    bit [9:0] des;
    bit [9:0] e_c_en;
    bit [1:0] e_lives;
    bit       e_go;
    bit       e_pulse;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_lives = SL; m_go = 0; m_pulse = 0;
    m_act = '0; m_prev = '0; m_lfsr = 'hA5;
    for (int i = 0; i < 10; i++) m_x[i] = 8'h00;
  endtask

  task automatic model_step(bit st, bit rn, bit [9:0] tch, bit [9:0] ds);
    int xr, esc, free, newl, fb;
    bit req;
    xr = (m_lfsr <= XM) ? m_lfsr : m_lfsr - (XM + 1);
    if (st) begin
      m_lives = SL; m_go = 0; m_act = '0; m_timer = 0; m_pulse = 0;
    end else begin
      req = 0;
      if (rn && !m_go) begin
        if (m_timer == P - 1) begin
          m_timer = 0;
          req = 1;
        end else begin
          m_timer++;
        end
      end
      free = -1;
      for (int i = 9; i >= 0; i--) if (!m_act[i]) free = i;
      esc = 0;
      for (int i = 0; i < 10; i++)
        if (m_act[i] && tch[i] && !m_prev[i] && !ds[i]) esc++;
      newl = m_lives - esc;
      if (newl < 0) newl = 0;
      m_pulse = 0;
      if (m_lives > 0 && newl == 0) begin
        m_go = 1;
        m_act = '0;
      end else begin
        for (int i = 0; i < 10; i++)
          if (m_act[i] && (ds[i] || (tch[i] && !m_prev[i]))) m_act[i] = 0;
        if (req && free >= 0) begin
          m_act[free] = 1;
          m_x[free] = 8'(xr);
          m_pulse = 1;
        end
      end
      m_lives = newl;
    end
    m_prev = tch;
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 255;
  endtask

  task automatic compare_model(string tag);
    logic [79:0] xp;
    for (int i = 0; i < 10; i++) xp[8*i +: 8] = m_x[i];
    chk({tag, " c_en"}, 80'(bus.c_en), 80'(m_act));
    chk({tag, " x_out"}, bus.x_out, xp);
    chk({tag, " spawn_pulse"}, 80'(bus.spawn_pulse), 80'(m_pulse));
    chk({tag, " lives"}, 80'(bus.lives), 80'(m_lives));
    chk({tag, " game_over"}, 80'(bus.game_over), 80'(m_go));
  endtask

  // Drive one cycle of inputs, advance model and DUT, sample 1 time unit after the edge.
  task automatic apply(bit st, bit rn, bit [9:0] tch, bit [9:0] ds, string tag);
    bus.start = st; bus.run = rn; bus.touch_edge = tch; bus.des = ds;
    model_step(st, rn, tch, ds);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic add(bit st, bit rn, bit [9:0] tch, bit [9:0] ds,
                     bit [9:0] ec, bit [1:0] el, bit eg, bit ep);
    vec_t v;
    v.start = st; v.run = rn; v.touch = tch; v.des = ds;
    v.e_c_en = ec; v.e_lives = el; v.e_go = eg; v.e_pulse = ep;
    tbl.push_back(v);
  endtask

  initial begin
    bit [9:0] tch;
    bit [9:0] ds;
    bit st, rn;

    // Directed vectors; row r is checked right after edge r+1 following reset release.
    for (int k = 0; k < 44; k++) begin
      int s, cnt;
      s = (k + 1) / 4;
      cnt = (s > 10) ? 10 : s;
      add(0, 1, '0, '0, 10'((1 << cnt) - 1), 2'd3, 0, ((k + 1) % 4 == 0) && (s <= 10));
    end
    add(0, 1, '0, 10'h008, 10'h3F7, 2'd3, 0, 0);  // reuse: free slot 3
    add(0, 1, '0, '0,      10'h3F7, 2'd3, 0, 0);
    add(0, 1, '0, '0,      10'h3F7, 2'd3, 0, 0);
    add(0, 1, '0, '0,      10'h3FF, 2'd3, 0, 1);  // slot 3 refilled
    add(0, 0, 10'h003, '0, 10'h3FC, 2'd1, 0, 0);  // two escapes at once
    add(0, 0, 10'h003, '0, 10'h3FC, 2'd1, 0, 0);  // held level is ignored
    add(0, 0, 10'h007, 10'h004, 10'h3F8, 2'd1, 0, 0);  // des + touch on slot 2
    add(0, 0, 10'h007, '0, 10'h3F8, 2'd1, 0, 0);
    add(0, 0, 10'h00F, '0, 10'h000, 2'd0, 1, 0);  // last life lost
    for (int k = 0; k < 5; k++) add(0, 1, 10'h00F, '0, 10'h000, 2'd0, 1, 0);
    add(1, 1, '0, '0, 10'h000, 2'd3, 0, 0);       // restart
    for (int k = 0; k < 3; k++) add(0, 1, '0, '0, 10'h000, 2'd3, 0, 0);
    add(0, 1, '0, '0, 10'h001, 2'd3, 0, 1);

    bus.start = 0; bus.run = 0; bus.touch_edge = '0; bus.des = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset c_en", 80'(bus.c_en), 80'h0);
    chk("reset x_out", bus.x_out, 80'h0);
    chk("reset spawn_pulse", 80'(bus.spawn_pulse), 80'h0);
    chk("reset lives", 80'(bus.lives), 80'(SL));
    chk("reset game_over", 80'(bus.game_over), 80'h0);
    @(negedge clk);
    reset = 0;

    foreach (tbl[r]) begin
      apply(tbl[r].start, tbl[r].run, tbl[r].touch, tbl[r].des, $sformatf("row%0d model", r));
      chk($sformatf("row%0d c_en", r), 80'(bus.c_en), 80'(tbl[r].e_c_en));
      chk($sformatf("row%0d lives", r), 80'(bus.lives), 80'(tbl[r].e_lives));
      chk($sformatf("row%0d game_over", r), 80'(bus.game_over), 80'(tbl[r].e_go));
      chk($sformatf("row%0d spawn_pulse", r), 80'(bus.spawn_pulse), 80'(tbl[r].e_pulse));
      if (r == 3) begin
        // LFSR A5 -> 4A -> 95 -> 2A at the request cycle; 2A is below X_MAX.
        chk("first_x", 80'(bus.x_out[7:0]), 80'h2A);
        chk("first_x_le_xmax", 80'(bus.x_out[7:0] <= 8'(XM)), 80'h1);
      end
    end

    // Randomized play against the model.
    tch = '0;
    for (int n = 0; n < 800; n++) begin
      tch = tch ^ 10'($urandom & $urandom & $urandom);
      ds  = 10'($urandom & $urandom & $urandom & $urandom);
      st  = ($urandom_range(0, 59) == 0);
      rn  = ($urandom_range(0, 9) != 0);
      apply(st, rn, tch, ds, $sformatf("rand%0d", n));
    end

    // Async reset in the middle of a game.
    apply(1, 1, '0, '0, "pre_reset start");
    for (int k = 0; k < 10; k++) apply(0, 1, '0, '0, "pre_reset run");
    chk("pre_reset c_en", 80'(bus.c_en), 80'h003);
    #2;
    reset = 1;
    #1;
    chk("async c_en", 80'(bus.c_en), 80'h0);
    chk("async x_out", bus.x_out, 80'h0);
    chk("async lives", 80'(bus.lives), 80'(SL));
    chk("async spawn_pulse", 80'(bus.spawn_pulse), 80'h0);
    @(negedge clk);
    reset = 0;
    model_reset();
    for (int k = 0; k < 4; k++) apply(0, 1, '0, '0, "post_reset");
    chk("post_reset first spawn", 80'(bus.c_en), 80'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
